// File: rtl/bcd_display_counter.sv
// bcd_display_counter: N-digit BCD up/down counter with a prescaled count
// tick, clear/load/enable control, a roll-over pulse and a time-multiplexed
// common-anode 7-segment driver with registered anode and segment outputs.
module bcd_display_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  system_clock,
    input  logic                  system_reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]       SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [6:0]          GLYPH_ZERO = 7'b1000000;

    // Clamp every digit of a load word to a legal BCD value (>9 becomes 9).
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        end
        return r;
    endfunction

    // One BCD increment (inc=1) or decrement (inc=0) with ripple carry/borrow.
    function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                     input logic inc);
        logic [4*DIGITS-1:0] r;
        logic [3:0]          d;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (carry) begin
                if (inc) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    // Active-low segment pattern {g..a} for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            default: seg_decode = 7'b0010000;
        endcase
    endfunction

    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          cur_digit;
    logic                tick;

    assign tick = en && (presc_q == PRESC_LAST);

    // Count path: clear beats load beats tick; wrap only on a real roll-over.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            presc_d = '0;
            count_d = bcd_clamp(load_value);
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = bcd_step(count_q, up);
                wrap_d  = up ? (count_q == ALL_NINES) : (count_q == '0);
            end
        end
    end

    // Scan timing: free-running dwell counter stepping the lit-digit index.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Display path: select the digit under scan and build anode/segment words.
    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = count_q[4*k +: 4];
            end
        end
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = seg_decode(cur_digit);
    end

    // State registers; reset returns counter, scan and display to digit 0 showing "0".
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= GLYPH_ZERO;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Testbench for bcd_display_counter (DIGITS=2, PRESCALE=4, SCAN_DIV=2):
// a cycle model pushes expected outputs into a queue, popped after each edge.
module tb_bcd_display_counter;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;

    typedef struct {
        logic [7:0] count;
        logic       wrap;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] count;
    logic       wrap;
    logic [1:0] an;
    logic [6:0] seg;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    int         m_cnt = 0, m_presc = 0, m_scan = 0, m_idx = 0;
    logic       m_wrap = 1'b0;
    logic [1:0] m_an = 2'b10;
    logic [6:0] m_seg = 7'b1000000;

    bcd_display_counter #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .system_clock(clk), .system_reset(rst), .en(en), .up(up),
        .clear(clear), .load(load), .load_value(load_value),
        .count(count), .wrap(wrap), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Advance the model by one clock, queue its outputs, clock the DUT, compare.
    task automatic step();
        exp_t e;
        int   d, lo, hi;
        bit   tick;
        if (rst) begin
            m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0;
            m_wrap = 1'b0; m_an = 2'b10; m_seg = 7'b1000000;
        end else begin
            d     = (m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10);
            m_an  = (m_idx == 0) ? 2'b10 : 2'b01;
            m_seg = seg7(d);
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % DIGITS;
            end else begin
                m_scan++;
            end
            tick   = en && (m_presc == PRESCALE - 1);
            m_wrap = 1'b0;
            if (clear) begin
                m_cnt = 0; m_presc = 0;
            end else if (load) begin
                lo = (load_value[3:0] > 9) ? 9 : int'(load_value[3:0]);
                hi = (load_value[7:4] > 9) ? 9 : int'(load_value[7:4]);
                m_cnt = hi * 10 + lo; m_presc = 0;
            end else if (en) begin
                m_presc = tick ? 0 : m_presc + 1;
                if (tick) begin
                    if (up) begin
                        if (m_cnt == 99) begin m_cnt = 0; m_wrap = 1'b1; end
                        else m_cnt = m_cnt + 1;
                    end else begin
                        if (m_cnt == 0) begin m_cnt = 99; m_wrap = 1'b1; end
                        else m_cnt = m_cnt - 1;
                    end
                end
            end
        end
        e.count = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        e.wrap  = m_wrap;
        e.an    = m_an;
        e.seg   = m_seg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_count", count, e.count);
        check("sb_wrap",  wrap,  e.wrap);
        check("sb_an",    an,    e.an);
        check("sb_seg",   seg,   e.seg);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int wraps;

    initial begin
        // Reset
        rst = 1'b1;
        run(2);
        check("rst_count", count, 8'h00);
        check("rst_an", an, 2'b10);
        check("rst_seg", seg, 7'b1000000);
        check("rst_wrap", wrap, 1'b0);

        // 1: free counting, ten ticks in forty cycles
        rst = 1'b0; en = 1'b1; up = 1'b1;
        run(40);
        check("t1_count10", count, 8'h10);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (an == 2'b10) check("t1_seg_lo", seg, 7'b1000000);
            if (an == 2'b01) check("t1_seg_hi", seg, 7'b1111001);
        end

        // 2: 98 -> 99 -> 00 with one wrap pulse
        load = 1'b1; load_value = 8'h98;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1; wraps = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wrap) begin
                wraps++;
                check("t2_wrap_at00", count, 8'h00);
            end
        end
        check("t2_wraps", wraps, 1);
        check("t2_count", count, 8'h00);

        // 3: 01 -> 00 -> 99 with one wrap pulse
        load = 1'b1; load_value = 8'h01;
        step();
        load = 1'b0; up = 1'b0; wraps = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wrap) begin
                wraps++;
                check("t3_wrap_at99", count, 8'h99);
            end
        end
        check("t3_wraps", wraps, 1);
        check("t3_count", count, 8'h99);

        // 4: hold at 37 with en=0, display keeps scanning
        load = 1'b1; load_value = 8'h36;
        step();
        load = 1'b0; up = 1'b1;
        run(6);
        check("t4_count37", count, 8'h37);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (an == 2'b10) check("t4_seg7", seg, 7'b1111000);
            if (an == 2'b01) check("t4_seg3", seg, 7'b0110000);
        end
        check("t4_hold", count, 8'h37);
        en = 1'b1;
        step();
        check("t4_resume1", count, 8'h37);
        step();
        check("t4_resume2", count, 8'h38);

        // 5: clamped load, load+tick, clear+load+tick
        en = 1'b0; load = 1'b1; load_value = 8'hFA;
        step();
        check("t5_clamp", count, 8'h99);
        load = 1'b0; en = 1'b1; up = 1'b1;
        run(3);
        load = 1'b1; load_value = 8'h99;
        step();
        check("t5_loadtick_cnt", count, 8'h99);
        check("t5_loadtick_wrap", wrap, 1'b0);
        load = 1'b0;
        run(3);
        clear = 1'b1; load = 1'b1; load_value = 8'h42;
        step();
        check("t5_clr_cnt", count, 8'h00);
        check("t5_clr_wrap", wrap, 1'b0);
        clear = 1'b0; load = 1'b0;

        // 6: reset mid-count at 55
        en = 1'b0; load = 1'b1; load_value = 8'h55;
        step();
        load = 1'b0; en = 1'b1;
        run(3);
        check("t6_count55", count, 8'h55);
        rst = 1'b1;
        step();
        check("t6_count", count, 8'h00);
        check("t6_an", an, 2'b10);
        check("t6_seg", seg, 7'b1000000);
        check("t6_wrap", wrap, 1'b0);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        run(8);
        check("t6_restart", count, 8'h02);

        // Random mix against the model
        for (int i = 0; i < 200; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            up         = $urandom_range(0, 1) != 0;
            clear      = ($urandom_range(0, 40) == 0);
            load       = ($urandom_range(0, 25) == 0);
            load_value = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_counter.md
Name: bcd_display_counter

Overview:
- Parametrised successor to the 8-bit free-running counter / LED decoder pair.
- Implements an N-digit BCD up/down counter with:
  - prescaled count tick,
  - enable, synchronous clear and parallel load,
  - wrap pulse.
- Drives a time-multiplexed common-anode 7-segment display directly: one digit at a time, registered outputs.
- Sits between the board clock/reset and the display pins; the count is also exported for other logic.

Parameters:
- DIGITS, 4, number of BCD digits and display anodes (1..8).
- PRESCALE, 50000, system_clock cycles per count tick (>=1).
- SCAN_DIV, 1000, system_clock cycles each digit stays lit (>=1).

Ports:
- system_clock  input  1  single clock; all logic on rising edge.
- system_reset  input  1  synchronous, active-high reset.
- en  input  1  1 = prescaler runs and ticks advance count; 0 = prescaler and count hold.
- up  input  1  1 = increment, 0 = decrement; sampled on tick cycle.
- clear  input  1  synchronous count/prescaler clear.
- load  input  1  synchronous parallel load.
- load_value  input  4*DIGITS  BCD load data; digit k in bits [4k+3:4k].
- count  output  4*DIGITS  current BCD count, registered.
- wrap  output  1  one-cycle pulse on roll-over (up) or roll-under (down).
- an  output  DIGITS  anode enables, active-low, one-hot-low.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (system_reset=1 at edge):
  - count=0, wrap=0, prescaler=0, scan counter=0, digit index=0.
  - an = all ones except bit0 = 0.
  - seg = 7'b1000000 (glyph "0").
- Priority at each edge: system_reset > clear > load > tick.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1 and wraps to 0.
  - tick is asserted internally in the cycle it equals PRESCALE-1.
  - en=0 freezes the prescaler value.
  - PRESCALE=1 gives a tick every enabled cycle.
- clear:
  - count=0 and prescaler=0 next edge; wrap=0.
- load:
  - count=load_value next edge; prescaler=0; wrap=0.
  - Any loaded digit >9 is stored as 9.
- tick with up=1:
  - BCD increment with per-digit carry (9 -> 0, carry to the next digit).
  - All-9s -> all-0s, with wrap=1 in the same cycle count changes.
- tick with up=0:
  - BCD decrement with borrow (0 -> 9).
  - All-0s -> all-9s, with wrap=1.
- wrap is high for exactly one cycle. It is 0 whenever count does not roll over.
- Count latency: count changes on the edge ending the tick cycle (1 cycle after the prescaler reaches PRESCALE-1).
- Scan:
  - Scan counter runs continuously, independent of en/clear/load. It resets only on system_reset.
  - Every SCAN_DIV cycles the digit index advances 0,1,…,DIGITS-1,0.
- Display outputs:
  - an and seg are registered from the current index and the current count digit.
  - They reflect a count change or index change 1 cycle later.
  - an never has more than one low bit.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Digit 0 is least significant and drives an[0].
- Reset mid-count or mid-scan: all state returns to the reset values at that edge, with no residual wrap pulse.
- Simultaneous clear+load+tick: clear wins and no wrap is generated.
- load+tick: load wins and no wrap is generated.

Test Plan (DIGITS=2, PRESCALE=4, SCAN_DIV=2):
1. Reset release, en=1, up=1, 40 cycles:
   - count steps 00,01,02… every 4 cycles; 10 ticks gives count=10.
   - an alternates 10/01 every 2 cycles.
   - seg matches the digit under scan: "0"=1000000 when an=10 after ten ticks, "1"=1111001 when an=01.
2. Load 8'h98, up=1, en=1:
   - Next ticks give 99, then 00.
   - wrap is high for exactly the cycle count becomes 00; 0 elsewhere.
3. Load 8'h01, up=0:
   - Ticks give 00 then 99.
   - wrap pulses once on the 00->99 transition.
4. en=0 for 20 cycles mid-count at 37:
   - count stays 37 and the prescaler holds.
   - The display still scans, showing "7" on an=10 and "3" on an=01.
   - After en=1, the next tick occurs after the remaining prescale cycles.
5. Load 8'hFA:
   - count=99 (both digits clamped).
   - Then clear, load and tick asserted in the same cycle: count=00, wrap=0.
6. system_reset asserted at count=55 during a scan:
   - Next edge: count=00, an=10, seg=1000000, wrap=0.
   - Counting restarts from 00 after release.
